// File: rtl/riscv_ifu_align.sv
// rtl/riscv_ifu_align.sv - fetch-word to instruction aligner and issue sequencer for riscv_idu
// Optional RVC alignment is enabled by defining RISCV_C_EN.
module riscv_ifu_align #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect_vld,
   input  logic [31:0] redirect_addr,
   input  logic        fetch_vld,
   output logic        fetch_rdy,
   input  logic [31:0] fetch_addr,
   input  logic [31:0] fetch_data,
   output logic        ifu_vld,
   input  logic        ifu_rdy,
   output logic [31:0] ifu_addr,
   output logic [31:0] ifu_data
);

`ifdef RISCV_C_EN
   localparam logic [31:0] RESET_PC = {RESET_ADDR[31:1], 1'b0};
   typedef enum logic [1:0] {EMPTY, LO, HI, SPLIT} state_t;
`else
   localparam logic [31:0] RESET_PC = {RESET_ADDR[31:2], 2'b00};
   typedef enum logic {EMPTY, LO} state_t;
`endif

   state_t      state, nxt_state;
   logic [31:0] pc, nxt_pc, cur_word, nxt_word, redirect_pc;
   logic [31:0] iss_data, eff_word;
   logic        issue, have_word, consumed, out_free, flush;
   logic        unused_bits;
`ifdef RISCV_C_EN
   logic [15:0] hold, nxt_hold;
   logic [31:0] pc_p2;
   logic        eff_hi;
`endif

   assign out_free    = !ifu_vld || ifu_rdy;
   assign flush       = reset || redirect_vld;
   assign unused_bits = ^{fetch_addr[1:0], redirect_addr[1:0]};
`ifdef RISCV_C_EN
   assign redirect_pc = {redirect_addr[31:1], 1'b0};
   assign pc_p2       = pc + 32'd2;
`else
   assign redirect_pc = {redirect_addr[31:2], 2'b00};
`endif

   // A word accepted in EMPTY is aligned in the same cycle so its first
   // instruction is registered onto ifu_* at the accepting edge.
   always_comb begin
      nxt_state = state;
      nxt_pc    = pc;
      nxt_word  = cur_word;
      issue     = 1'b0;
      iss_data  = 32'h0;
      consumed  = 1'b0;
      have_word = 1'b0;
      eff_word  = cur_word;
`ifdef RISCV_C_EN
      nxt_hold  = hold;
      eff_hi    = (state == HI);
`endif
      case (state)
         EMPTY: begin
            if (fetch_vld && out_free && fetch_addr[31:2] == pc[31:2]) begin
               have_word = 1'b1;
               eff_word  = fetch_data;
`ifdef RISCV_C_EN
               eff_hi    = pc[1];
`endif
            end
         end
         LO: have_word = out_free;
`ifdef RISCV_C_EN
         HI: have_word = out_free;
         SPLIT: begin
            if (fetch_vld && out_free && fetch_addr[31:2] == pc_p2[31:2]) begin
               issue     = 1'b1;
               iss_data  = {fetch_data[15:0], hold};
               nxt_pc    = pc + 32'd4;
               nxt_word  = fetch_data;
               nxt_state = HI;
            end
         end
`endif
         default: ;
      endcase

      if (have_word) begin
`ifdef RISCV_C_EN
         if (!eff_hi) begin
            issue = 1'b1;
            if (eff_word[1:0] != 2'b11) begin
               iss_data  = {16'h0, eff_word[15:0]};
               nxt_pc    = pc + 32'd2;
               nxt_word  = eff_word;
               nxt_state = HI;
            end else begin
               iss_data = eff_word;
               nxt_pc   = pc + 32'd4;
               consumed = 1'b1;
            end
         end else if (eff_word[17:16] != 2'b11) begin
            issue    = 1'b1;
            iss_data = {16'h0, eff_word[31:16]};
            nxt_pc   = pc + 32'd2;
            consumed = 1'b1;
         end else begin
            nxt_hold  = eff_word[31:16];
            nxt_state = SPLIT;
         end
`else
         issue    = 1'b1;
         iss_data = eff_word;
         nxt_pc   = pc + 32'd4;
         consumed = 1'b1;
`endif
      end

      // A consumed word is replaced by a same-cycle fetch; nxt_pc is word aligned here.
      if (consumed) begin
         nxt_state = EMPTY;
         if (state != EMPTY && fetch_vld && fetch_addr[31:2] == nxt_pc[31:2]) begin
            nxt_word  = fetch_data;
            nxt_state = LO;
         end
      end
   end

   always_comb begin
      fetch_rdy = 1'b0;
      if (!flush) begin
         case (state)
            EMPTY:   fetch_rdy = out_free || (fetch_addr[31:2] != pc[31:2]);
`ifdef RISCV_C_EN
            SPLIT:   fetch_rdy = out_free;
`endif
            default: fetch_rdy = consumed;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (flush) begin
         state    <= EMPTY;
         pc       <= reset ? RESET_PC : redirect_pc;
         cur_word <= 32'h0;
         ifu_vld  <= 1'b0;
`ifdef RISCV_C_EN
         hold     <= 16'h0;
`endif
         if (reset) begin
            ifu_addr <= 32'h0;
            ifu_data <= 32'h0;
         end
      end else begin
         state    <= nxt_state;
         pc       <= nxt_pc;
         cur_word <= nxt_word;
`ifdef RISCV_C_EN
         hold     <= nxt_hold;
`endif
         if (issue) begin
            ifu_vld  <= 1'b1;
            ifu_addr <= pc;
            ifu_data <= iss_data;
         end else if (ifu_rdy) begin
            ifu_vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_riscv_ifu_align.sv
// tb/tb_riscv_ifu_align.sv - scoreboard bench for riscv_ifu_align
module tb_riscv_ifu_align;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_vld = 1'b0;
   logic [31:0] redirect_addr = 32'h0;
   logic        fetch_vld = 1'b0;
   logic        fetch_rdy;
   logic [31:0] fetch_addr = 32'h0;
   logic [31:0] fetch_data = 32'h0;
   logic        ifu_vld;
   logic        ifu_rdy = 1'b1;
   logic [31:0] ifu_addr;
   logic [31:0] ifu_data;

   int          tests = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_acc = 0;
   logic [63:0] exp_q[$];
   int          iss_cyc_q[$];

   riscv_ifu_align #(.RESET_ADDR(32'h0)) dut (
      .clock(clock), .reset(reset),
      .redirect_vld(redirect_vld), .redirect_addr(redirect_addr),
      .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy),
      .fetch_addr(fetch_addr), .fetch_data(fetch_data),
      .ifu_vld(ifu_vld), .ifu_rdy(ifu_rdy),
      .ifu_addr(ifu_addr), .ifu_data(ifu_data)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (ifu_vld && ifu_rdy) begin
         logic [63:0] e;
         tests++;
         iss_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL issue_unexpected: got addr=%h data=%h, required no issue", ifu_addr, ifu_data);
         end else begin
            e = exp_q.pop_front();
            if ({ifu_addr, ifu_data} !== e) begin
               errors++;
               $display("FAIL issue: got addr=%h data=%h, required addr=%h data=%h",
                        ifu_addr, ifu_data, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      tests++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic expect_iss(input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
   task automatic send_word(input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      fetch_vld  = 1'b1;
      fetch_addr = a;
      fetch_data = d;
      @(negedge clock);
      while (!fetch_rdy && n < 50) begin
         @(negedge clock);
         n++;
      end
      tests++;
      if (!fetch_rdy) begin
         errors++;
         $display("FAIL fetch_accept_timeout: addr %h never accepted, required acceptance", a);
      end
      @(posedge clock);
      #1;
      last_acc  = cyc;
      fetch_vld = 1'b0;
   endtask

   task automatic do_redirect(input logic [31:0] a);
      redirect_vld  = 1'b1;
      redirect_addr = a;
      @(posedge clock);
      #1;
      redirect_vld = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      tests++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d pending issues, required 0", name, exp_q.size());
         exp_q.delete();
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      int acc4;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset_ifu_vld", {31'h0, ifu_vld}, 32'h0);
      check("reset_ifu_addr", ifu_addr, 32'h0);
      check("reset_ifu_data", ifu_data, 32'h0);
      check("reset_fetch_rdy", {31'h0, fetch_rdy}, 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("empty_fetch_rdy", {31'h0, fetch_rdy}, 32'h1);
      @(posedge clock);
      #1;

      // aligned 32-bit stream, consecutive issues
      iss_cyc_q.delete();
      expect_iss(32'h0, 32'h0000_0013);
      expect_iss(32'h4, 32'h0000_0013);
      send_word(32'h0, 32'h0000_0013);
      check("first_latency", {31'h0, ifu_vld}, 32'h1);
      send_word(32'h4, 32'h0000_0013);
      wait_drain("aligned");
      check("aligned_consecutive", iss_cyc_q[1] - iss_cyc_q[0], 32'd1);

`ifdef RISCV_C_EN
      // mixed RVC word
      do_redirect(32'h0);
      expect_iss(32'h0, 32'h0000_4501);
      expect_iss(32'h2, 32'h0000_0001);
      send_word(32'h0, 32'h0001_4501);
      @(negedge clock);
      check("rvc_hi_fetch_rdy", {31'h0, fetch_rdy}, 32'h1);
      @(posedge clock);
      #1;
      wait_drain("rvc");

      // straddling 32-bit instruction
      do_redirect(32'h0);
      iss_cyc_q.delete();
      expect_iss(32'h0, 32'h0000_4501);
      expect_iss(32'h2, 32'h0000_0013);
      expect_iss(32'h6, 32'h0000_0000);
      send_word(32'h0, 32'h0013_4501);
      send_word(32'h4, 32'h0000_0000);
      acc4 = last_acc;
      wait_drain("straddle");
      check("straddle_latency", iss_cyc_q[1], acc4);
`else
      // RVC-looking word issued whole
      do_redirect(32'h0);
      expect_iss(32'h0, 32'h0000_4501);
      expect_iss(32'h4, 32'h0001_2345);
      send_word(32'h0, 32'h0000_4501);
      send_word(32'h4, 32'h0001_2345);
      wait_drain("noc_word");
      acc4 = last_acc;
`endif

      // back-pressure mid-stream
      do_redirect(32'h40);
      expect_iss(32'h40, 32'h0000_0093);
      expect_iss(32'h44, 32'h0010_0113);
      expect_iss(32'h48, 32'h0020_0193);
      ifu_rdy = 1'b0;
      send_word(32'h40, 32'h0000_0093);
      fetch_vld  = 1'b1;
      fetch_addr = 32'h44;
      fetch_data = 32'h0010_0113;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("bp_fetch_rdy", {31'h0, fetch_rdy}, 32'h0);
         check("bp_ifu_addr", ifu_addr, 32'h40);
         check("bp_ifu_data", ifu_data, 32'h0000_0093);
      end
      @(posedge clock);
      #1;
      ifu_rdy = 1'b1;
      send_word(32'h44, 32'h0010_0113);
      send_word(32'h48, 32'h0020_0193);
      wait_drain("backpressure");

      // redirect with a fetch word offered in the same cycle
      ifu_rdy = 1'b0;
      send_word(32'h4C, 32'h0030_0213);
      redirect_vld  = 1'b1;
      redirect_addr = 32'h102;
      fetch_vld     = 1'b1;
      fetch_addr    = 32'h100;
      fetch_data    = 32'hDEAD_BEEF;
      @(negedge clock);
      check("redirect_fetch_rdy", {31'h0, fetch_rdy}, 32'h0);
      @(posedge clock);
      #1;
      redirect_vld = 1'b0;
      fetch_vld    = 1'b0;
      ifu_rdy      = 1'b1;
      @(negedge clock);
      check("redirect_ifu_vld", {31'h0, ifu_vld}, 32'h0);
      @(posedge clock);
      #1;
`ifdef RISCV_C_EN
      expect_iss(32'h102, 32'h0000_4501);
`else
      expect_iss(32'h100, 32'h4501_0013);
`endif
      send_word(32'h100, 32'h4501_0013);
      wait_drain("redirect");

      // mismatching word dropped in EMPTY
      expect_iss(32'h104, 32'h0000_0093);
      send_word(32'h200, 32'hFFFF_FFFF);
      send_word(32'h104, 32'h0000_0093);
      wait_drain("drop");

      // pc wrap
      do_redirect(32'hFFFF_FFFE);
`ifdef RISCV_C_EN
      expect_iss(32'hFFFF_FFFE, 32'h0000_0013);
      send_word(32'hFFFF_FFFC, 32'h0013_0001);
      send_word(32'h0, 32'h0093_0000);
`else
      expect_iss(32'hFFFF_FFFC, 32'h0000_0013);
      expect_iss(32'h0, 32'h0000_0093);
      send_word(32'hFFFF_FFFC, 32'h0000_0013);
      send_word(32'h0, 32'h0000_0093);
`endif
      wait_drain("wrap");

      // mid-stream reset
      reset = 1'b1;
      @(negedge clock);
      check("midreset_fetch_rdy", {31'h0, fetch_rdy}, 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("midreset_ifu_vld", {31'h0, ifu_vld}, 32'h0);
      check("midreset_ifu_addr", ifu_addr, 32'h0);
      expect_iss(32'h0, 32'h0000_0013);
      send_word(32'h0, 32'h0000_0013);
      wait_drain("midreset");
      check("acc_sanity", {31'h0, acc4 > 0}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end
endmodule
